// File: rtl/chan_pkt_framer.sv
// chan_pkt_framer: wraps each channelizer payload in a framed packet
// (header word, payload beats, trailer word) behind one output register.
`timescale 1ns/1ps

module chan_pkt_framer #(
    parameter int          DATA_WIDTH = 32,
    parameter int          USER_WIDTH = 24,
    parameter int          MAX_LEN    = 4096,
    parameter logic [15:0] SYNC_WORD  = 16'hA5C3
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           trunc_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_TRL  = 2'd3;

    localparam logic [15:0] MAX_LEN_W = MAX_LEN[15:0];

    logic [1:0]  state;
    logic [10:0] chan;
    logic [15:0] seq;
    logic [15:0] beat_cnt;
    logic        trunc;

    logic        out_free;
    logic        beat_take;
    logic [15:0] beat_next;
    logic        at_limit;

    // Only the bin index of tuser is meaningful to the framer.
    logic        unused_user;
    assign unused_user = ^s_axis_tuser[USER_WIDTH-1:11];

    // The output register can take a new word when empty or being drained.
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == ST_DATA) && out_free;
    assign beat_take     = s_axis_tvalid && s_axis_tready;
    assign beat_next     = beat_cnt + 16'd1;
    assign at_limit      = (beat_next == MAX_LEN_W);

    // Framing FSM and the single output register stage.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; later assignments in the block override the
    // earlier default (word taken -> valid low) without inferring anything extra.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state         <= ST_IDLE;
            chan          <= '0;
            seq           <= '0;
            beat_cnt      <= '0;
            trunc         <= 1'b0;
            trunc_cnt     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    // Peek at the first beat's tag without consuming it.
                    if (s_axis_tvalid) begin
                        chan  <= s_axis_tuser[10:0];
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (out_free) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= {SYNC_WORD, seq[4:0], chan};
                        m_axis_tlast  <= 1'b0;
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_take) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tlast  <= 1'b0;
                        beat_cnt      <= beat_next;
                        // A real tlast wins over the length limit on the same beat.
                        if (s_axis_tlast) begin
                            trunc <= 1'b0;
                            state <= ST_TRL;
                        end else if (at_limit) begin
                            trunc     <= 1'b1;
                            trunc_cnt <= trunc_cnt + 16'd1;
                            state     <= ST_TRL;
                        end
                    end
                end
                ST_TRL: begin
                    if (out_free) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= {trunc, 15'd0, beat_cnt};
                        m_axis_tlast  <= 1'b1;
                        beat_cnt      <= '0;
                        seq           <= seq + 16'd1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Count packets whose trailer has actually been handed downstream.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            pkt_cnt <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_chan_pkt_framer.sv
// tb_chan_pkt_framer: randomized bench for chan_pkt_framer. Two instances
// (default MAX_LEN and MAX_LEN=16) are checked against a packet-level model.
`timescale 1ns/1ps

module tb_chan_pkt_framer;

    localparam int BIG_LEN   = 4096;
    localparam int SMALL_LEN = 16;

    logic clk        = 1'b0;
    logic sync_reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]        s_valid = '0, s_last = '0, s_ready, m_valid, m_last, m_ready;
    logic [1:0][31:0]  s_data = '0, m_data;
    logic [1:0][23:0]  s_user = '0;
    logic [1:0][15:0]  pkt_cnt, trunc_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state per instance.
    logic [15:0] ref_seq[2], ref_pkt[2], ref_trunc[2];
    logic [32:0] exp0[$], exp1[$], obs0[$], obs1[$];
    logic [31:0] pay_d[$];
    logic [23:0] pay_u[$];
    logic        pay_l[$];
    int          ready_mode[2];
    int          gap_pct = 0;

    chan_pkt_framer #(.MAX_LEN(BIG_LEN)) dut_big (
        .clk(clk), .sync_reset(sync_reset),
        .s_axis_tvalid(s_valid[0]), .s_axis_tdata(s_data[0]), .s_axis_tuser(s_user[0]),
        .s_axis_tlast(s_last[0]), .s_axis_tready(s_ready[0]),
        .m_axis_tvalid(m_valid[0]), .m_axis_tdata(m_data[0]), .m_axis_tlast(m_last[0]),
        .m_axis_tready(m_ready[0]), .pkt_cnt(pkt_cnt[0]), .trunc_cnt(trunc_cnt[0])
    );

    chan_pkt_framer #(.MAX_LEN(SMALL_LEN)) dut_small (
        .clk(clk), .sync_reset(sync_reset),
        .s_axis_tvalid(s_valid[1]), .s_axis_tdata(s_data[1]), .s_axis_tuser(s_user[1]),
        .s_axis_tlast(s_last[1]), .s_axis_tready(s_ready[1]),
        .m_axis_tvalid(m_valid[1]), .m_axis_tdata(m_data[1]), .m_axis_tlast(m_last[1]),
        .m_axis_tready(m_ready[1]), .pkt_cnt(pkt_cnt[1]), .trunc_cnt(trunc_cnt[1])
    );

    // Downstream ready pattern: 0 = always ready, 1 = 5 on / 10 off, 2 = random.
    int phase = 0;
    initial begin
        m_ready       = '1;
        ready_mode[0] = 0;
        ready_mode[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % 15;
            for (int u = 0; u < 2; u++) begin
                case (ready_mode[u])
                    1:       m_ready[u] = (phase < 5);
                    2:       m_ready[u] = 1'($urandom_range(0, 1));
                    default: m_ready[u] = 1'b1;
                endcase
            end
        end
    end

    // Output monitor: capture transfers and check hold-while-stalled.
    logic [1:0]       prev_stall = '0;
    logic [1:0][32:0] prev_word  = '0;
    always @(negedge clk) begin
        if (sync_reset) begin
            prev_stall = '0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (prev_stall[u]) begin
                    checks++;
                    if (!m_valid[u] || {m_last[u], m_data[u]} !== prev_word[u]) begin
                        errors++;
                        $display("FAIL stall_hold u%0d got v=%0b w=%h need v=1 w=%h",
                                 u, m_valid[u], {m_last[u], m_data[u]}, prev_word[u]);
                    end
                end
                if (m_valid[u] && m_ready[u]) begin
                    if (u == 0) obs0.push_back({m_last[u], m_data[u]});
                    else        obs1.push_back({m_last[u], m_data[u]});
                end
                prev_stall[u] = m_valid[u] && !m_ready[u];
                prev_word[u]  = {m_last[u], m_data[u]};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int u, input logic [32:0] w);
        if (u == 0) exp0.push_back(w);
        else        exp1.push_back(w);
    endtask

    task automatic clear_payload();
        pay_d.delete();
        pay_u.delete();
        pay_l.delete();
    endtask

    // Append one channelizer payload to the stimulus stream.
    task automatic make_payload(input logic [10:0] chan, input int n, input bit counting,
                                input bit vary);
        logic [23:0] r;
        for (int i = 0; i < n; i++) begin
            r = 24'($urandom);
            pay_d.push_back(counting ? 32'(i + 1) : $urandom);
            pay_u.push_back((vary && i > 0) ? r : {r[23:11], chan});
            pay_l.push_back(i == n - 1);
        end
    endtask

    // Packet-level model: header from the tag of the packet's first beat,
    // close on tlast, otherwise force-close at max_len beats.
    task automatic model_stream(input int u);
        int          max_len;
        int          cnt;
        bit          start;
        logic [10:0] chan;
        max_len = (u == 0) ? BIG_LEN : SMALL_LEN;
        cnt     = 0;
        start   = 1'b1;
        chan    = '0;
        for (int i = 0; i < pay_d.size(); i++) begin
            if (start) begin
                chan = pay_u[i][10:0];
                push_exp(u, {1'b0, 16'hA5C3, ref_seq[u][4:0], chan});
                start = 1'b0;
            end
            push_exp(u, {1'b0, pay_d[i]});
            cnt++;
            if (pay_l[i] || cnt == max_len) begin
                push_exp(u, {1'b1, !pay_l[i], 15'd0, 16'(cnt)});
                if (!pay_l[i]) ref_trunc[u]++;
                ref_pkt[u]++;
                ref_seq[u]++;
                start = 1'b1;
                cnt   = 0;
            end
        end
    endtask

    // Drive the first n beats of the stimulus stream; entered and left at posedge+1.
    task automatic drive(input int u, input int n);
        int budget;
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_valid[u] = 1'b0;
                @(posedge clk);
                #1;
            end
            s_valid[u] = 1'b1;
            s_data[u]  = pay_d[i];
            s_user[u]  = pay_u[i];
            s_last[u]  = pay_l[i];
            budget     = 300;
            forever begin
                @(negedge clk);
                if (s_ready[u]) break;
                budget--;
                if (budget == 0) break;
            end
            if (budget == 0) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout u%0d beat %0d got no tready need tready", u, i);
                s_valid[u] = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        if (n == pay_d.size()) s_valid[u] = 1'b0;
    endtask

    task automatic wait_drain(input int u);
        int budget;
        budget = 20000;
        while (budget > 0 && ((u == 0) ? (obs0.size() != exp0.size())
                                        : (obs1.size() != exp1.size()))) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout u%0d got %0d words need %0d", u,
                     (u == 0) ? obs0.size() : obs1.size(), (u == 0) ? exp0.size() : exp1.size());
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input int u, input string name);
        logic [32:0] e[$], o[$];
        logic [32:0] ew, ow;
        int          k;
        if (u == 0) begin e = exp0; o = obs0; exp0.delete(); obs0.delete(); end
        else        begin e = exp1; o = obs1; exp1.delete(); obs1.delete(); end
        checks++;
        if (o.size() !== e.size()) begin
            errors++;
            $display("FAIL %s_len u%0d got %0d words need %0d", name, u, o.size(), e.size());
        end
        k = 0;
        while (e.size() > 0 && o.size() > 0) begin
            ew = e.pop_front();
            ow = o.pop_front();
            checks++;
            if (ow !== ew) begin
                errors++;
                $display("FAIL %s_word u%0d #%0d got last=%0b %h need last=%0b %h",
                         name, u, k, ow[32], ow[31:0], ew[32], ew[31:0]);
            end
            k++;
        end
        checks++;
        if (pkt_cnt[u] !== ref_pkt[u]) begin
            errors++;
            $display("FAIL %s_pkt_cnt u%0d got %0d need %0d", name, u, pkt_cnt[u], ref_pkt[u]);
        end
        checks++;
        if (trunc_cnt[u] !== ref_trunc[u]) begin
            errors++;
            $display("FAIL %s_trunc_cnt u%0d got %0d need %0d", name, u, trunc_cnt[u], ref_trunc[u]);
        end
    endtask

    task automatic check_zero(input string name);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({m_valid[u], m_last[u], s_ready[u]} !== 3'b000 || m_data[u] !== 32'd0 ||
                pkt_cnt[u] !== 16'd0 || trunc_cnt[u] !== 16'd0) begin
                errors++;
                $display("FAIL %s u%0d got v=%0b l=%0b rdy=%0b d=%h pkt=%0d tr=%0d need all 0",
                         name, u, m_valid[u], m_last[u], s_ready[u], m_data[u],
                         pkt_cnt[u], trunc_cnt[u]);
            end
        end
    endtask

    task automatic reset_model();
        for (int u = 0; u < 2; u++) begin
            ref_seq[u]   = '0;
            ref_pkt[u]   = '0;
            ref_trunc[u] = '0;
        end
        exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
    endtask

    task automatic run(input int u, input string name);
        model_stream(u);
        drive(u, pay_d.size());
        wait_drain(u);
        compare(u, name);
    endtask

    task automatic test_reset();
        reset_model();
        sync_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        sync_reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        clear_payload();
        make_payload(11'd5, 8, 1'b1, 1'b0);
        model_stream(0);
        drive(0, 8);
        wait_drain(0);
        checks++;
        if (obs0.size() < 10 || obs0[0] !== {1'b0, 32'hA5C30005} || obs0[9] !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL single_frame got %0d words hdr=%h need hdr=0a5c30005 trl=100000008",
                     obs0.size(), (obs0.size() > 0) ? obs0[0] : 33'd0);
        end
        compare(0, "single");
    endtask

    task automatic test_back_to_back();
        clear_payload();
        make_payload(11'd3, 4, 1'b0, 1'b0);
        make_payload(11'd2047, 4, 1'b0, 1'b0);
        run(0, "b2b");
    endtask

    task automatic test_stall();
        ready_mode[0] = 1;
        clear_payload();
        make_payload(11'($urandom), 1000, 1'b0, 1'b0);
        make_payload(11'($urandom), 1000, 1'b0, 1'b0);
        run(0, "stall");
        ready_mode[0] = 0;
    endtask

    task automatic test_trunc();
        clear_payload();
        make_payload(11'd9, 20, 1'b0, 1'b1);
        run(1, "trunc");
    endtask

    task automatic test_tlast_at_limit();
        clear_payload();
        make_payload(11'd100, SMALL_LEN, 1'b0, 1'b0);
        run(1, "tlast_limit");
    endtask

    task automatic test_random();
        gap_pct = 20;
        for (int it = 0; it < 8; it++) begin
            ready_mode[it % 2] = 2;
            clear_payload();
            for (int p = 0; p < int'($urandom_range(1, 3)); p++)
                make_payload(11'($urandom), int'($urandom_range(1, 40)), 1'b0, 1'b1);
            run(it % 2, "random");
            ready_mode[it % 2] = 0;
        end
        gap_pct = 0;
    endtask

    task automatic test_mid_reset();
        clear_payload();
        make_payload(11'd7, 10, 1'b0, 1'b0);
        drive(0, 5);
        #3;
        sync_reset = 1'b1;
        #1;
        check_zero("mid_reset");
        s_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        sync_reset = 1'b0;
        reset_model();
        @(posedge clk);
        #1;
        clear_payload();
        make_payload(11'd12, 6, 1'b0, 1'b0);
        model_stream(0);
        drive(0, 6);
        wait_drain(0);
        checks++;
        if (obs0.size() == 0 || obs0[0] !== {1'b0, 32'hA5C3000C}) begin
            errors++;
            $display("FAIL post_reset_header got %h need 0a5c3000c",
                     (obs0.size() > 0) ? obs0[0] : 33'd0);
        end
        compare(0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_trunc();
        test_tlast_at_limit();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
